ps2_interface: RTL and testbench
================================

Name: ps2_interface

Overview:
Bidirectional PS/2 host-side interface running on the 100 MHz system clock. It receives 11-bit device-to-host frames, validates them, and presents each byte with a one-cycle strobe. It also transmits host-to-device command bytes using the standard inhibit / request-to-send sequence. It sits between the board's PS/2 pins (open-drain, bidirectional) and the game/VGA control logic.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency; used to derive the timing constants below.
FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2_clk/ps2_data changes.
INHIBIT_CYCLES, 10000, clk cycles ps2_clk is held low before a transmit (100 us).
TIMEOUT_CYCLES, 200000, clk cycles without a filtered ps2_clk falling edge, mid-frame, before the frame is abandoned (2 ms).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
ps2_clk  inout  1  PS/2 clock line; open-drain: driven 0 or high-Z only.
ps2_data  inout  1  PS/2 data line; open-drain: driven 0 or high-Z only.
rx_data  output  8  last correctly received byte.
read_data  output  1  one-cycle pulse when rx_data is updated.
tx_data  input  8  byte to transmit.
write_data  input  1  transmit request; sampled when busy=0.
busy  output  1  high while a transmit is in progress.
err  output  1  one-cycle pulse on a receive framing/parity error, a timeout, or a missing transmit ack.

Behaviour:
- Reset (rst=0, asynchronous): rx_data=0x00, read_data=0, busy=0, err=0, both lines released (Z), FSM in IDLE, bit counter 0.
- Input conditioning: 2-flop synchronizer per line, then a glitch filter. The filtered value flips only after FILTER_LEN consecutive equal samples. A falling edge is detected when the filtered clock goes 1->0 and is registered as a single-cycle event.
- RX frame: start(0), d0..d7 (LSB first), odd parity, stop(1). The frame is sampled on filtered ps2_clk falling edges.
  - Valid frame: rx_data loads the byte and read_data=1 for exactly one clk cycle, both in the cycle after the stop-bit edge.
  - Start=1 at the first edge: ignore that edge and remain idle.
  - Parity wrong or stop=0: frame discarded, rx_data unchanged, err pulse, no read_data.
- Timeout: mid-frame (RX or TX), more than TIMEOUT_CYCLES without a falling edge discards the frame, pulses err and returns to IDLE.
- TX FSM: IDLE -> INHIBIT -> RTS -> SEND -> ACK -> IDLE.
  - IDLE: on write_data=1 with busy=0 and no RX frame in progress, latch tx_data and set busy=1 next cycle.
  - INHIBIT: drive ps2_clk low for INHIBIT_CYCLES.
  - RTS: drive ps2_data low (start bit), then release ps2_clk.
  - SEND: on each device falling edge, present the next bit: d0..d7, then odd parity, then release data for the stop bit.
  - ACK: on the next falling edge, ps2_data=0 means success; ps2_data=1 means err pulse.
  - busy clears when both lines return high, or on error.
- write_data while busy=1 is ignored.
- The receiver is disabled while busy=1.
- If write_data arrives while an RX frame is in progress, the RX frame completes first and the request is then accepted provided write_data is still high.
- Lines are never driven high; undriven lines rely on the external pull-ups.

Test Plan:
- RX good byte: device sends 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> rx_data=0x1C, read_data high exactly 1 cycle, err=0.
- RX parity error: send 0x1C with parity bit 1 -> rx_data keeps its previous value, no read_data, one err pulse.
- Glitch rejection: a 40 ns low pulse on ps2_clk while idle -> no state change. A following valid 0xF0 frame -> rx_data=0xF0.
- Timeout: send start plus 3 bits, then hold ps2_clk high for 2.5 ms -> err pulse. A subsequent valid 0x29 frame is received correctly.
- TX: write_data pulse with tx_data=0xED ->
  - busy=1;
  - ps2_clk low for 100 us;
  - ps2_data low before clk is released;
  - device clocks out bits 1,0,1,1,0,1,1,1, parity 1;
  - device ack 0 -> busy falls, err=0.
- Reset mid-frame: assert rst low after 5 RX bits -> outputs immediately return to reset values and lines are released. After release, a full 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_interface.sv
// PS/2 host-side interface: filtered receive of device frames and
// host-to-device command transmission over open-drain clock/data lines.
`timescale 1ns/1ps
module ps2_interface #(
   parameter int unsigned CLK_FREQ_HZ    = 100000000,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned INHIBIT_CYCLES = CLK_FREQ_HZ / 10000,
   parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ / 500
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic [7:0] rx_data,
   output logic       read_data,
   input  logic [7:0] tx_data,
   input  logic       write_data,
   output logic       busy,
   output logic       err
);

   // state      | meaning
   // S_IDLE     | lines released, waiting for a start bit or a write request
   // S_RX       | receiving data/parity/stop bits from the device
   // S_INHIBIT  | host holds ps2_clk low
   // S_RTS      | data held low (start bit), then ps2_clk released
   // S_SEND     | shifting d0..d7, parity, then releasing data for stop
   // S_ACK      | waiting for the device ack bit
   // S_ACK_WAIT | ack seen, waiting for both lines to return high

   typedef enum logic [2:0] {
      S_IDLE, S_RX, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_ACK_WAIT
   } state_t;

   localparam int          FW         = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);
   localparam int unsigned RTS_CYCLES = (INHIBIT_CYCLES / 50 > 0) ? INHIBIT_CYCLES / 50 : 1;

   logic [1:0]    clk_sync, data_sync;
   logic [FW-1:0] clk_cnt, data_cnt;
   logic          clk_f, data_f, clk_f_d, fall;

   state_t      state, state_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [8:0]  tx_shift, tx_shift_nxt;
   logic [31:0] tmr, tmr_nxt;
   logic        par_ok, par_ok_nxt;
   logic        clk_low, clk_low_nxt;
   logic        data_low, data_low_nxt;
   logic [7:0]  rx_data_nxt;
   logic        read_nxt, err_nxt;

   assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = data_low ? 1'b0 : 1'bz;

   // A filtered line flips only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_cnt   <= FLT_LOAD;
         data_cnt  <= FLT_LOAD;
         clk_f     <= 1'b1;
         data_f    <= 1'b1;
         clk_f_d   <= 1'b1;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         if (clk_sync[1] == clk_f) begin
            clk_cnt <= FLT_LOAD;
         end else if (clk_cnt == '0) begin
            clk_f   <= clk_sync[1];
            clk_cnt <= FLT_LOAD;
         end else begin
            clk_cnt <= clk_cnt - 1'b1;
         end
         if (data_sync[1] == data_f) begin
            data_cnt <= FLT_LOAD;
         end else if (data_cnt == '0) begin
            data_f   <= data_sync[1];
            data_cnt <= FLT_LOAD;
         end else begin
            data_cnt <= data_cnt - 1'b1;
         end
         clk_f_d <= clk_f;
         fall    <= clk_f_d & ~clk_f;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         bit_cnt   <= 4'd0;
         shift     <= 8'h00;
         tx_shift  <= 9'h000;
         tmr       <= 32'd0;
         par_ok    <= 1'b0;
         clk_low   <= 1'b0;
         data_low  <= 1'b0;
         rx_data   <= 8'h00;
         read_data <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift     <= shift_nxt;
         tx_shift  <= tx_shift_nxt;
         tmr       <= tmr_nxt;
         par_ok    <= par_ok_nxt;
         clk_low   <= clk_low_nxt;
         data_low  <= data_low_nxt;
         rx_data   <= rx_data_nxt;
         read_data <= read_nxt;
         err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      shift_nxt    = shift;
      tx_shift_nxt = tx_shift;
      tmr_nxt      = tmr;
      par_ok_nxt   = par_ok;
      clk_low_nxt  = 1'b0;
      data_low_nxt = data_low;
      rx_data_nxt  = rx_data;
      read_nxt     = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         S_IDLE: begin
            data_low_nxt = 1'b0;
            bit_cnt_nxt  = 4'd0;
            if (write_data) begin
               tx_shift_nxt = {~^tx_data, tx_data};
               tmr_nxt      = INHIBIT_CYCLES - 32'd1;
               clk_low_nxt  = 1'b1;
               state_nxt    = S_INHIBIT;
            end else if (fall && !data_f) begin
               tmr_nxt   = TIMEOUT_CYCLES;
               state_nxt = S_RX;
            end
         end
         S_RX: begin
            if (fall) begin
               tmr_nxt     = TIMEOUT_CYCLES;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (bit_cnt < 4'd8) begin
                  shift_nxt = {data_f, shift[7:1]};
               end else if (bit_cnt == 4'd8) begin
                  par_ok_nxt = (^shift) ^ data_f;
               end else begin
                  if (data_f && par_ok) begin
                     rx_data_nxt = shift;
                     read_nxt    = 1'b1;
                  end else begin
                     err_nxt = 1'b1;
                  end
                  state_nxt = S_IDLE;
               end
            end else if (tmr == 32'd0) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmr_nxt = tmr - 32'd1;
            end
         end
         S_INHIBIT: begin
            clk_low_nxt = 1'b1;
            if (tmr == 32'd0) begin
               tmr_nxt      = RTS_CYCLES - 32'd1;
               data_low_nxt = 1'b1;
               state_nxt    = S_RTS;
            end else begin
               tmr_nxt = tmr - 32'd1;
            end
         end
         S_RTS: begin
            // Hold clk low briefly with data low, then wait for the released clk to read high.
            data_low_nxt = 1'b1;
            if (tmr != 32'd0) begin
               clk_low_nxt = 1'b1;
               tmr_nxt     = tmr - 32'd1;
            end else if (clk_f) begin
               tmr_nxt     = TIMEOUT_CYCLES;
               bit_cnt_nxt = 4'd0;
               state_nxt   = S_SEND;
            end
         end
         S_SEND: begin
            if (fall) begin
               tmr_nxt = TIMEOUT_CYCLES;
               if (bit_cnt < 4'd9) begin
                  data_low_nxt = ~tx_shift[0];
                  tx_shift_nxt = {1'b0, tx_shift[8:1]};
                  bit_cnt_nxt  = bit_cnt + 4'd1;
               end else begin
                  data_low_nxt = 1'b0;
                  state_nxt    = S_ACK;
               end
            end else if (tmr == 32'd0) begin
               data_low_nxt = 1'b0;
               err_nxt      = 1'b1;
               state_nxt    = S_IDLE;
            end else begin
               tmr_nxt = tmr - 32'd1;
            end
         end
         S_ACK: begin
            if (fall) begin
               tmr_nxt = TIMEOUT_CYCLES;
               if (!data_f) begin
                  state_nxt = S_ACK_WAIT;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end else if (tmr == 32'd0) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmr_nxt = tmr - 32'd1;
            end
         end
         S_ACK_WAIT: begin
            if (clk_f && data_f) begin
               state_nxt = S_IDLE;
            end else if (tmr == 32'd0) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmr_nxt = tmr - 32'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_INHIBIT) || (state == S_RTS) || (state == S_SEND) ||
                 (state == S_ACK) || (state == S_ACK_WAIT);

endmodule

// File: tb/tb_ps2_interface.sv
// Directed bench for ps2_interface: a device model drives/reads the open-drain
// lines; expectations are hand-computed PS/2 frames.
`timescale 1ns/1ps
module tb_ps2_interface;

   localparam int HALF = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       write_data = 1'b0;
   logic [7:0] rx_data;
   logic       read_data, busy, err;
   wire        ps2_clk, ps2_data;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int checks = 0;
   int failures = 0;
   int read_cnt = 0;
   int err_cnt = 0;
   int r0, e0;

   logic [9:0] seen;
   int         low_cyc;
   logic       data_rel, busy_start, done_ok;

   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   ps2_interface #(
      .CLK_FREQ_HZ(100000000),
      .FILTER_LEN(8),
      .INHIBIT_CYCLES(100),
      .TIMEOUT_CYCLES(2000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .rx_data(rx_data),
      .read_data(read_data),
      .tx_data(tx_data),
      .write_data(write_data),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (read_data) read_cnt++;
      if (err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic dev_bit(input logic b);
      dev_data_low = ~b;
      #HALF;
      dev_clk_low = 1'b1;
      #HALF;
      dev_clk_low = 1'b0;
   endtask

   task automatic dev_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int nbits);
      logic [10:0] f;
      f = {stop, (~^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < nbits; i++) dev_bit(f[i]);
      #HALF;
      dev_data_low = 1'b0;
   endtask

   task automatic dev_tx(input logic [7:0] d, input logic give_ack,
                         output logic [9:0] bits, output int lowc,
                         output logic d_rel, output logic b_start, output logic ok);
      @(negedge clk);
      tx_data    = d;
      write_data = 1'b1;
      @(negedge clk);
      write_data = 1'b0;
      b_start    = busy;
      lowc       = 0;
      while (ps2_clk === 1'b0 && lowc < 1000) begin
         @(negedge clk);
         lowc++;
      end
      d_rel = ps2_data;
      #HALF;
      for (int i = 0; i < 10; i++) begin
         dev_clk_low = 1'b1;
         #HALF;
         bits[i]     = ps2_data;
         dev_clk_low = 1'b0;
         #HALF;
      end
      if (give_ack) dev_data_low = 1'b1;
      #HALF;
      dev_clk_low = 1'b1;
      #HALF;
      dev_clk_low = 1'b0;
      #HALF;
      dev_data_low = 1'b0;
      for (int i = 0; i < 500 && busy; i++) @(negedge clk);
      ok = ~busy;
   endtask

   initial begin
      #52;
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst_read_data", {31'd0, read_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
      chk("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);

      r0 = read_cnt; e0 = err_cnt;
      dev_frame(8'h1C, 1'b0, 1'b1, 11);
      chk("rx_1c_data", {24'd0, rx_data}, 32'h1C);
      chk("rx_1c_read", read_cnt - r0, 32'd1);
      chk("rx_1c_err", err_cnt - e0, 32'd0);

      r0 = read_cnt; e0 = err_cnt;
      dev_frame(8'h1C, 1'b1, 1'b1, 11);
      chk("par_err_data", {24'd0, rx_data}, 32'h1C);
      chk("par_err_read", read_cnt - r0, 32'd0);
      chk("par_err_err", err_cnt - e0, 32'd1);

      r0 = read_cnt; e0 = err_cnt;
      dev_frame(8'h55, 1'b0, 1'b0, 11);
      chk("stop_err_data", {24'd0, rx_data}, 32'h1C);
      chk("stop_err_read", read_cnt - r0, 32'd0);
      chk("stop_err_err", err_cnt - e0, 32'd1);

      r0 = read_cnt; e0 = err_cnt;
      @(negedge clk);
      dev_clk_low = 1'b1;
      #40;
      dev_clk_low = 1'b0;
      #500;
      chk("glitch_read", read_cnt - r0, 32'd0);
      chk("glitch_err", err_cnt - e0, 32'd0);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
      dev_frame(8'hF0, 1'b0, 1'b1, 11);
      chk("rx_f0_data", {24'd0, rx_data}, 32'hF0);
      chk("rx_f0_read", read_cnt - r0, 32'd1);
      chk("rx_f0_err", err_cnt - e0, 32'd0);

      r0 = read_cnt; e0 = err_cnt;
      dev_frame(8'h29, 1'b0, 1'b1, 4);
      repeat (1500) @(negedge clk);
      chk("timeout_early", err_cnt - e0, 32'd0);
      repeat (1000) @(negedge clk);
      chk("timeout_err", err_cnt - e0, 32'd1);
      chk("timeout_read", read_cnt - r0, 32'd0);
      dev_frame(8'h29, 1'b0, 1'b1, 11);
      chk("rx_29_data", {24'd0, rx_data}, 32'h29);
      chk("rx_29_read", read_cnt - r0, 32'd1);

      e0 = err_cnt;
      dev_tx(8'hED, 1'b1, seen, low_cyc, data_rel, busy_start, done_ok);
      chk("tx_ed_busy", {31'd0, busy_start}, 32'd1);
      chk("tx_ed_inhibit", {31'd0, (low_cyc >= 100 && low_cyc <= 106)}, 32'd1);
      chk("tx_ed_rts_data", {31'd0, data_rel}, 32'd0);
      chk("tx_ed_bits", {22'd0, seen}, {22'd0, 1'b1, 1'b1, 8'hED});
      chk("tx_ed_done", {31'd0, done_ok}, 32'd1);
      chk("tx_ed_err", err_cnt - e0, 32'd0);

      e0 = err_cnt;
      dev_tx(8'h5A, 1'b0, seen, low_cyc, data_rel, busy_start, done_ok);
      chk("tx_5a_bits", {22'd0, seen}, {22'd0, 1'b1, 1'b1, 8'h5A});
      chk("tx_noack_done", {31'd0, done_ok}, 32'd1);
      chk("tx_noack_err", err_cnt - e0, 32'd1);

      dev_frame(8'h1C, 1'b0, 1'b1, 5);
      rst = 1'b0;
      #1;
      chk("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("mid_rst_read", {31'd0, read_data}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_clk_line", {31'd0, ps2_clk}, 32'd1);
      chk("mid_rst_data_line", {31'd0, ps2_data}, 32'd1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      r0 = read_cnt; e0 = err_cnt;
      dev_frame(8'h1C, 1'b0, 1'b1, 11);
      chk("post_rst_data", {24'd0, rx_data}, 32'h1C);
      chk("post_rst_read", read_cnt - r0, 32'd1);
      chk("post_rst_err", err_cnt - e0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
